// File: rtl/multicycle_alu_pkg.sv
// Shared opcode and state encodings for the handshaked multi-cycle ALU.
package multicycle_alu_pkg;

  localparam int ALU_OP_WIDTH = 4;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SLL  = 4'h5,
    OP_SRL  = 4'h6,
    OP_SRA  = 4'h7,
    OP_SLT  = 4'h8,
    OP_SLTU = 4'h9,
    OP_MUL  = 4'hA
  } aluOperation_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } aluState_t;

endpackage

// File: rtl/multicycle_alu_mul_iter.sv
// Iterative shift-add multiplier: BITS_PER_CYC multiplier bits retired per cycle, fixed iteration count.
module multicycle_alu_mul_iter #(
  parameter int DATA_WIDTH   = 64,
  parameter int BITS_PER_CYC = 1
) (
  input  logic                  clk_in,
  input  logic                  resetN_in,
  input  logic                  start_in,
  input  logic [DATA_WIDTH-1:0] mcand_in,
  input  logic [DATA_WIDTH-1:0] mplier_in,
  output logic                  done_out,
  output logic [DATA_WIDTH-1:0] product_out
);

  localparam int ITERS = DATA_WIDTH / BITS_PER_CYC;
  localparam int CNT_W = $clog2(ITERS) + 1;

  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] acc_step_s;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  last_s;

  assign last_s      = busy_q && (cnt_q == CNT_W'(ITERS - 1));
  // The final accumulation is exposed combinationally so the top can register it on the last iteration.
  assign done_out    = last_s;
  assign product_out = acc_step_s;

  // Accumulate the partial products for the bits retired this cycle.
  always_comb begin
    acc_step_s = acc_q;
    for (int i = 0; i < BITS_PER_CYC; i++) begin
      if (mplier_q[i]) begin
        acc_step_s = acc_step_s + (mcand_q << i);
      end else begin
        acc_step_s = acc_step_s;
      end
    end
  end

  // Next-state for operand shifters, accumulator and iteration counter.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_in) begin
      mcand_d  = mcand_in;
      mplier_d = mplier_in;
      acc_d    = {DATA_WIDTH{1'b0}};
      cnt_d    = {CNT_W{1'b0}};
      busy_d   = 1'b1;
    end else if (busy_q) begin
      mcand_d  = mcand_q << BITS_PER_CYC;
      mplier_d = mplier_q >> BITS_PER_CYC;
      acc_d    = acc_step_s;
      cnt_d    = cnt_q + CNT_W'(1);
      busy_d   = !last_s;
    end else begin
      busy_d   = 1'b0;
    end
  end

  // Datapath registers; reset aborts any multiplication in flight.
  always_ff @(posedge clk_in or negedge resetN_in) begin
    if (!resetN_in) begin
      mcand_q  <= {DATA_WIDTH{1'b0}};
      mplier_q <= {DATA_WIDTH{1'b0}};
      acc_q    <= {DATA_WIDTH{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Handshaked execute-stage ALU: single-cycle arithmetic/logic/shift/compare ops plus an iterative multiply.
module multicycle_alu
  import multicycle_alu_pkg::*;
#(
  parameter int DATA_WIDTH_POW   = 6,
  parameter int MUL_BITS_PER_CYC = 1,
  localparam int DATA_WIDTH      = 1 << DATA_WIDTH_POW
) (
  input  logic                    clk_in,
  input  logic                    resetN_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic [DATA_WIDTH-1:0]   operand1_in,
  input  logic [DATA_WIDTH-1:0]   operand2_in,
  input  logic [ALU_OP_WIDTH-1:0] aluOp_in,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic [DATA_WIDTH-1:0]   result_out,
  output logic                    zeroFlag_out,
  output logic                    carryFlag_out,
  output logic                    overflowFlag_out
);

  aluState_t             state_q, state_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;
  logic                  carry_q, carry_d;
  logic                  ovf_q, ovf_d;

  logic                      accept_s, is_sub_s, mul_start_s, mul_done_s;
  logic [DATA_WIDTH-1:0]     add_b_s, add_sum_s, alu_res_s, mul_product_s;
  logic                      add_cout_s, add_ovf_s, alu_carry_s, alu_ovf_s, alu_zero_s;
  logic [DATA_WIDTH_POW-1:0] shamt_s;

  assign ready_out   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && ready_in);
  assign accept_s    = valid_in && ready_out;
  assign mul_start_s = accept_s && (aluOp_in == OP_MUL);
  assign is_sub_s    = (aluOp_in == OP_SUB);
  assign add_b_s     = is_sub_s ? ~operand2_in : operand2_in;
  assign shamt_s     = operand2_in[DATA_WIDTH_POW-1:0];

  // Ripple-carry adder shared by ADD and SUB (SUB is a + ~b + 1).
  always_comb begin : ripple_add
    logic c_v;
    c_v       = is_sub_s;
    add_sum_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < DATA_WIDTH; i++) begin
      add_sum_s[i] = operand1_in[i] ^ add_b_s[i] ^ c_v;
      c_v          = (operand1_in[i] & add_b_s[i]) | (c_v & (operand1_in[i] ^ add_b_s[i]));
    end
    add_cout_s = c_v;
    add_ovf_s  = (operand1_in[DATA_WIDTH-1] == add_b_s[DATA_WIDTH-1]) &&
                 (add_sum_s[DATA_WIDTH-1] != operand1_in[DATA_WIDTH-1]);
  end

  // Single-cycle result and flags; unknown opcodes yield zero result with all flags clear.
  always_comb begin
    alu_res_s   = {DATA_WIDTH{1'b0}};
    alu_carry_s = 1'b0;
    alu_ovf_s   = 1'b0;
    alu_zero_s  = 1'b0;
    case (aluOp_in)
      OP_ADD, OP_SUB: begin
        alu_res_s   = add_sum_s;
        alu_carry_s = add_cout_s;
        alu_ovf_s   = add_ovf_s;
      end
      OP_AND:  alu_res_s = operand1_in & operand2_in;
      OP_OR:   alu_res_s = operand1_in | operand2_in;
      OP_XOR:  alu_res_s = operand1_in ^ operand2_in;
      OP_SLL:  alu_res_s = operand1_in << shamt_s;
      OP_SRL:  alu_res_s = operand1_in >> shamt_s;
      OP_SRA:  alu_res_s = DATA_WIDTH'($signed(operand1_in) >>> shamt_s);
      OP_SLT:  alu_res_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(operand1_in) < $signed(operand2_in))};
      OP_SLTU: alu_res_s = {{(DATA_WIDTH-1){1'b0}}, (operand1_in < operand2_in)};
      default: alu_res_s = {DATA_WIDTH{1'b0}};
    endcase
    if ((aluOp_in == OP_MUL) || (aluOp_in > OP_MUL)) begin
      alu_zero_s = 1'b0;
    end else begin
      alu_zero_s = (alu_res_s == {DATA_WIDTH{1'b0}});
    end
  end

  multicycle_alu_mul_iter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BITS_PER_CYC(MUL_BITS_PER_CYC)
  ) u_mul (
    .clk_in     (clk_in),
    .resetN_in  (resetN_in),
    .start_in   (mul_start_s),
    .mcand_in   (operand1_in),
    .mplier_in  (operand2_in),
    .done_out   (mul_done_s),
    .product_out(mul_product_s)
  );

  // Handshake FSM next-state; a new accept overrides the DONE->IDLE drain in the same cycle.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: valid_d = 1'b0;
      ST_MUL: begin
        if (mul_done_s) begin
          state_d  = ST_DONE;
          valid_d  = 1'b1;
          result_d = mul_product_s;
          zero_d   = (mul_product_s == {DATA_WIDTH{1'b0}});
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
        end else begin
          valid_d  = 1'b0;
        end
      end
      ST_DONE: begin
        if (ready_in) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
    if (accept_s) begin
      if (aluOp_in == OP_MUL) begin
        state_d = ST_MUL;
        valid_d = 1'b0;
      end else begin
        state_d  = ST_DONE;
        valid_d  = 1'b1;
        result_d = alu_res_s;
        zero_d   = alu_zero_s;
        carry_d  = alu_carry_s;
        ovf_d    = alu_ovf_s;
      end
    end else begin
      state_d = state_d;
    end
  end

  // State and registered result/flags.
  always_ff @(posedge clk_in or negedge resetN_in) begin
    if (!resetN_in) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      result_q <= {DATA_WIDTH{1'b0}};
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign valid_out        = valid_q;
  assign result_out       = result_q;
  assign zeroFlag_out     = zero_q;
  assign carryFlag_out    = carry_q;
  assign overflowFlag_out = ovf_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed corner cases, randomized ops vs. an arithmetic model.
module tb_multicycle_alu;
  import multicycle_alu_pkg::*;

  localparam logic signed [64:0] SMAX = 65'sd9223372036854775807;
  localparam logic signed [64:0] SMIN = -65'sd9223372036854775808;

  logic        clk = 1'b0;
  logic        resetN_in, valid_in, ready_in;
  logic        ready_out, valid_out, zeroFlag_out, carryFlag_out, overflowFlag_out;
  logic [63:0] operand1_in, operand2_in, result_out;
  logic [3:0]  aluOp_in;

  int total = 0;
  int bad   = 0;

  logic [63:0] o_res;
  logic        o_z, o_c, o_v, o_rdy_busy;
  int          o_lat;

  always #5 clk = ~clk;

  multicycle_alu dut (
    .clk_in(clk), .resetN_in(resetN_in), .valid_in(valid_in), .ready_out(ready_out),
    .operand1_in(operand1_in), .operand2_in(operand2_in), .aluOp_in(aluOp_in),
    .valid_out(valid_out), .ready_in(ready_in), .result_out(result_out),
    .zeroFlag_out(zeroFlag_out), .carryFlag_out(carryFlag_out), .overflowFlag_out(overflowFlag_out)
  );

  function automatic void ref_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic z, output logic c, output logic v);
    logic signed [64:0] s;
    int sh;
    sh = int'(b % 64);
    r = 64'd0; c = 1'b0; v = 1'b0;
    case (op)
      4'h0: begin
        r = a + b;
        c = (r < a);
        s = $signed({a[63], a}) + $signed({b[63], b});
        v = (s > SMAX) || (s < SMIN);
      end
      4'h1: begin
        r = a - b;
        c = (a >= b);
        s = $signed({a[63], a}) - $signed({b[63], b});
        v = (s > SMAX) || (s < SMIN);
      end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = a << sh;
      4'h6: r = a >> sh;
      4'h7: r = 64'($signed(a) >>> sh);
      4'h8: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'h9: r = (a < b) ? 64'd1 : 64'd0;
      4'hA: r = a * b;
      default: r = 64'd0;
    endcase
    z = (op <= 4'hA) && (r == 64'd0);
  endfunction

  function automatic logic [63:0] rnd_operand();
    logic [63:0] sp [4];
    sp[0] = 64'd0; sp[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    sp[2] = 64'h8000_0000_0000_0000; sp[3] = 64'h7FFF_FFFF_FFFF_FFFF;
    case ($urandom_range(0, 3))
      0: return sp[$urandom_range(0, 3)];
      1: return 64'($urandom_range(0, 70));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Issue one operation with ready_in high and capture the result and its latency.
  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    aluOp_in = op; operand1_in = a; operand2_in = b; ready_in = 1'b1; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    o_lat = 1; o_rdy_busy = 1'b0;
    while (!valid_out && o_lat < 200) begin
      if (ready_out) o_rdy_busy = 1'b1;
      @(posedge clk); #1;
      o_lat++;
    end
    o_res = result_out; o_z = zeroFlag_out; o_c = carryFlag_out; o_v = overflowFlag_out;
  endtask

  task automatic test_reset();
    resetN_in = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    aluOp_in = 4'h0; operand1_in = 64'd0; operand2_in = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({ready_out, valid_out, result_out, zeroFlag_out, carryFlag_out, overflowFlag_out} !== {1'b1, 1'b0, 64'd0, 3'b000}) begin
      bad++;
      $display("FAIL reset_state got rdy=%b vld=%b res=%h z=%b c=%b v=%b want rdy=1 vld=0 res=0 flags=000",
               ready_out, valid_out, result_out, zeroFlag_out, carryFlag_out, overflowFlag_out);
    end
    @(negedge clk) resetN_in = 1'b1;
  endtask

  task automatic test_directed();
    run_op(4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    total++;
    if ({o_res, o_z, o_c, o_v} !== {64'd0, 3'b110} || o_lat != 1) begin
      bad++;
      $display("FAIL add_wrap got res=%h zcv=%b%b%b lat=%0d want res=0 zcv=110 lat=1", o_res, o_z, o_c, o_v, o_lat);
    end
    run_op(4'h1, 64'h8000_0000_0000_0000, 64'd1);
    total++;
    if (o_res !== 64'h7FFF_FFFF_FFFF_FFFF || o_v !== 1'b1 || o_c !== 1'b1 || o_z !== 1'b0) begin
      bad++;
      $display("FAIL sub_ovf got res=%h zcv=%b%b%b want res=7fffffffffffffff zcv=011", o_res, o_z, o_c, o_v);
    end
    run_op(4'h8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    total++;
    if (o_res !== 64'd1) begin bad++; $display("FAIL slt_neg got=%h want=1", o_res); end
    run_op(4'h9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    total++;
    if (o_res !== 64'd0 || o_z !== 1'b1) begin bad++; $display("FAIL sltu_neg got=%h z=%b want=0 z=1", o_res, o_z); end
    run_op(4'h7, 64'h8000_0000_0000_0000, 64'd63);
    total++;
    if (o_res !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL sra_63 got=%h want=ffffffffffffffff", o_res); end
    run_op(4'h5, 64'd1, 64'd64);
    total++;
    if (o_res !== 64'd1) begin bad++; $display("FAIL sll_mask got=%h want=1", o_res); end
  endtask

  task automatic test_mul();
    logic [63:0] a, b, er;
    logic ez, ec, ev;
    run_op(4'hA, 64'h1_0000_0001, 64'hFFFF_FFFF);
    total++;
    if (o_res !== 64'hFFFF_FFFF_FFFF_FFFF || o_lat != 65 || o_rdy_busy !== 1'b0) begin
      bad++;
      $display("FAIL mul_directed got res=%h lat=%0d rdy_busy=%b want res=ffffffffffffffff lat=65 rdy_busy=0",
               o_res, o_lat, o_rdy_busy);
    end
    for (int i = 0; i < 4; i++) begin
      a = rnd_operand(); b = rnd_operand();
      ref_alu(4'hA, a, b, er, ez, ec, ev);
      run_op(4'hA, a, b);
      total++;
      if (o_res !== er || {o_z, o_c, o_v} !== {ez, ec, ev} || o_lat != 65) begin
        bad++;
        $display("FAIL mul_rand a=%h b=%h got res=%h zcv=%b%b%b lat=%0d want res=%h zcv=%b%b%b lat=65",
                 a, b, o_res, o_z, o_c, o_v, o_lat, er, ez, ec, ev);
      end
    end
  endtask

  task automatic test_random_ops();
    logic [63:0] a, b, er;
    logic [3:0]  op;
    logic ez, ec, ev;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 9));
      a = rnd_operand(); b = rnd_operand();
      ref_alu(op, a, b, er, ez, ec, ev);
      run_op(op, a, b);
      total++;
      if (o_res !== er || o_lat != 1) begin
        bad++;
        $display("FAIL rand_res op=%h a=%h b=%h got=%h lat=%0d want=%h lat=1", op, a, b, o_res, o_lat, er);
      end
      total++;
      if ({o_z, o_c, o_v} !== {ez, ec, ev}) begin
        bad++;
        $display("FAIL rand_flags op=%h a=%h b=%h got zcv=%b%b%b want zcv=%b%b%b", op, a, b, o_z, o_c, o_v, ez, ec, ev);
      end
    end
  endtask

  task automatic test_illegal();
    for (int op = 11; op < 16; op++) begin
      run_op(4'(op), {$urandom, $urandom}, {$urandom, $urandom});
      total++;
      if (o_res !== 64'd0 || o_c !== 1'b0 || o_v !== 1'b0 || o_lat != 1) begin
        bad++;
        $display("FAIL illegal_op op=%h got res=%h c=%b v=%b lat=%0d want res=0 c=0 v=0 lat=1", op, o_res, o_c, o_v, o_lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a, b, er;
    logic [3:0]  op;
    logic ez, ec, ev;
    @(negedge clk);
    ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(0, 9));
      a = rnd_operand(); b = rnd_operand();
      ref_alu(op, a, b, er, ez, ec, ev);
      aluOp_in = op; operand1_in = a; operand2_in = b; valid_in = 1'b1;
      @(posedge clk); #1;
      total++;
      if (valid_out !== 1'b1 || ready_out !== 1'b1 || result_out !== er) begin
        bad++;
        $display("FAIL b2b[%0d] op=%h got vld=%b rdy=%b res=%h want vld=1 rdy=1 res=%h", i, op, valid_out, ready_out, result_out, er);
      end
    end
    valid_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    ready_in = 1'b0; valid_in = 1'b1; aluOp_in = 4'h0; operand1_in = 64'd100; operand2_in = 64'd23;
    @(posedge clk); #1;
    aluOp_in = 4'h1; operand1_in = 64'd7; operand2_in = 64'd7;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (valid_out !== 1'b1 || ready_out !== 1'b0 || result_out !== 64'd123 || zeroFlag_out !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d] got vld=%b rdy=%b res=%h z=%b want vld=1 rdy=0 res=7b z=0",
                 i, valid_out, ready_out, result_out, zeroFlag_out);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    valid_in = 1'b0; ready_in = 1'b1;
    @(posedge clk); #1;
    total++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1 || result_out !== 64'd123) begin
      bad++;
      $display("FAIL bp_release got vld=%b rdy=%b res=%h want vld=0 rdy=1 res=7b", valid_out, ready_out, result_out);
    end
    run_op(4'h1, 64'd7, 64'd7);
    total++;
    if (o_res !== 64'd0 || o_z !== 1'b1 || o_c !== 1'b1) begin
      bad++;
      $display("FAIL bp_next got res=%h z=%b c=%b want res=0 z=1 c=1", o_res, o_z, o_c);
    end
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    @(negedge clk);
    aluOp_in = 4'hA; operand1_in = 64'h1234_5678; operand2_in = 64'h9ABC_DEF0; ready_in = 1'b1; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (29) @(posedge clk);
    #2 resetN_in = 1'b0;
    #1;
    total++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      bad++;
      $display("FAIL mul_abort got vld=%b rdy=%b want vld=0 rdy=1", valid_out, ready_out);
    end
    @(negedge clk) resetN_in = 1'b1;
    seen = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (valid_out) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL mul_abort_stale got valid_cycles=%0d want 0", seen); end
    run_op(4'h0, 64'd2, 64'd3);
    total++;
    if (o_res !== 64'd5 || o_lat != 1) begin
      bad++;
      $display("FAIL post_reset_add got res=%h lat=%0d want res=5 lat=1", o_res, o_lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul();
    test_random_ops();
    test_illegal();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
